pkt_uart_tx: RTL and testbench

Transmit-side packet framer and UART serializer for the `bos` host link. It accepts a destination address, a length and a payload byte stream from an on-chip source. It emits the frame prefix, source address, destination address, length, payload and checksum as 8N1 UART characters on `tx`. It is the outbound counterpart of the host-to-FPGA frame parser and uses the same frame layout and bit timing.

---
 rtl/pkt_uart_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_pkt_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_uart_tx : bos host-link frame builder with an 8N1 UART serializer.
// Optional macro PKT_TX_GAP_EN appends 3 bit-times of idle after each char.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pkt_uart_tx #(
  parameter int unsigned CLK_HZ  = 48000000,
  parameter int unsigned BAUD    = 115200,
  parameter logic [7:0]  PREFIX  = 8'hDD,
  parameter logic [7:0]  MY_ADDR = 8'h01
) (
  input  logic       fpga_clk_48,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] dest,
  input  logic [7:0] len,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(3 * DIV + 1);
  // The final cycle of every character tail is spent in S_IDLE_BIT, where the
  // framer loads the next byte so characters stay exactly back-to-back.
`ifdef PKT_TX_GAP_EN
  localparam int unsigned TAIL_LAST = 3 * DIV - 2;
`else
  localparam int unsigned TAIL_LAST = DIV - 2;
`endif

  typedef enum logic [2:0] {
    F_IDLE, F_PREFIX, F_SRC, F_DST, F_LEN, F_DATA, F_CRC
  } frm_e;

  typedef enum logic [2:0] {
    S_IDLE_BIT, S_START, S_BITS, S_STOP
`ifdef PKT_TX_GAP_EN
    , S_GAP
`endif
  } ser_e;

  frm_e             frm_q, frm_d;
  ser_e             ser_q, ser_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [7:0]       dest_q, dest_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       pay_q, pay_d;
  logic             crc_sent_q, crc_sent_d;
  logic             done_q, done_d;

  logic             w_ser_idle;
  logic             w_char_end;
  logic             w_load;
  logic [7:0]       w_load_byte;

  assign w_ser_idle = (ser_q == S_IDLE_BIT);
`ifdef PKT_TX_GAP_EN
  assign w_char_end = (ser_q == S_GAP)  && (cnt_q == CNT_W'(TAIL_LAST));
`else
  assign w_char_end = (ser_q == S_STOP) && (cnt_q == CNT_W'(TAIL_LAST));
`endif

  assign data_ready = (frm_q == F_DATA) && w_ser_idle;
  assign busy       = (frm_q != F_IDLE);
  assign done       = done_q;
  assign tx         = tx_q;

  always_comb begin
    frm_d       = frm_q;
    dest_d      = dest_q;
    len_d       = len_q;
    crc_d       = crc_q;
    pay_d       = pay_q;
    crc_sent_d  = crc_sent_q;
    done_d      = 1'b0;
    w_load      = 1'b0;
    w_load_byte = 8'h00;
    case (frm_q)
      F_IDLE: begin
        if (start) begin
          frm_d       = F_PREFIX;
          dest_d      = dest;
          len_d       = len;
          crc_d       = 8'h00;
          pay_d       = 8'h00;
          crc_sent_d  = 1'b0;
          w_load      = 1'b1;
          w_load_byte = PREFIX;
        end
      end
      F_PREFIX: if (w_char_end) frm_d = F_SRC;
      F_SRC: begin
        if (w_ser_idle) begin
          w_load      = 1'b1;
          w_load_byte = MY_ADDR;
        end
        if (w_char_end) frm_d = F_DST;
      end
      F_DST: begin
        if (w_ser_idle) begin
          w_load      = 1'b1;
          w_load_byte = dest_q;
        end
        if (w_char_end) frm_d = F_LEN;
      end
      F_LEN: begin
        if (w_ser_idle) begin
          w_load      = 1'b1;
          w_load_byte = len_q;
        end
        if (w_char_end) frm_d = (len_q != 8'h00) ? F_DATA : F_CRC;
      end
      F_DATA: begin
        if (data_ready && data_valid) begin
          w_load      = 1'b1;
          w_load_byte = data;
          crc_d       = crc_q ^ data;
          pay_d       = pay_q + 8'd1;
        end
        // pay_q counts accepted bytes, so it reaches 255 without wrapping
        if (w_char_end) frm_d = (pay_q == len_q) ? F_CRC : F_DATA;
      end
      F_CRC: begin
        if (w_ser_idle) begin
          if (!crc_sent_q) begin
            w_load      = 1'b1;
            w_load_byte = crc_q;
            crc_sent_d  = 1'b1;
          end else begin
            frm_d  = F_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: frm_d = F_IDLE;
    endcase
  end

  always_comb begin
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (ser_q)
      S_IDLE_BIT: begin
        if (w_load) begin
          ser_d   = S_START;
          cnt_d   = '0;
          shift_d = w_load_byte;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          ser_d = S_BITS;
          cnt_d = '0;
          bit_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BITS: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            ser_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PKT_TX_GAP_EN
      S_STOP: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          ser_d = S_GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (w_char_end) begin
          ser_d = S_IDLE_BIT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`else
      S_STOP: begin
        if (w_char_end) begin
          ser_d = S_IDLE_BIT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: ser_d = S_IDLE_BIT;
    endcase
  end

  assign tx_d = (ser_d == S_START) ? 1'b0 :
                (ser_d == S_BITS)  ? shift_d[0] : 1'b1;

  always_ff @(posedge fpga_clk_48 or negedge n_rst) begin
    if (!n_rst) begin
      frm_q      <= F_IDLE;
      ser_q      <= S_IDLE_BIT;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      dest_q     <= 8'h00;
      len_q      <= 8'h00;
      crc_q      <= 8'h00;
      pay_q      <= 8'h00;
      crc_sent_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      frm_q      <= frm_d;
      ser_q      <= ser_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      pay_q      <= pay_d;
      crc_sent_q <= crc_sent_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_uart_tx.sv
`default_nettype none
// tb_pkt_uart_tx : frame-level checks of pkt_uart_tx against a byte-list model
// with a UART line decoder; works for both gap and non-gap builds.
module tb_pkt_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef PKT_TX_GAP_EN
  localparam int GAPC = 3 * DIV;
`else
  localparam int GAPC = 0;
`endif
  localparam int CH = 10 * DIV + GAPC;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dest = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       busy;
  logic       done;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  pkt_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .PREFIX (8'hDD),
    .MY_ADDR(8'h01)
  ) dut (
    .fpga_clk_48(clk),
    .n_rst      (n_rst),
    .start      (start),
    .dest       (dest),
    .len        (len),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done),
    .tx         (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation counters, each written by this process only.
  int done_cnt = 0;
  int dr_cnt = 0;
  int run = 0;
  int runs[$];
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (data_ready === 1'b1) dr_cnt++;
    if (tx === 1'b0) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  // UART line decoder: mid-bit sampling, records byte and start cycle.
  logic [7:0] rx_b[$];
  int         rx_st[$];
  int         ferr = 0;
  initial begin : mon
    logic [7:0] b;
    int         st;
    bit         ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && n_rst === 1'b1) begin
        st = cyc;
        ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        rx_b.push_back(b);
        rx_st.push_back(st);
        if (!ok) ferr++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Sends one frame and checks it against the byte-list model.
  task automatic run_frame(input string tag, input logic [7:0] d, input int n,
                           input logic [63:0] pl, input int stall_idx,
                           input bit rnd_stall, input bit restart, input int exp_crc);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    int base_rx, base_done, base_dr, base_run, base_ferr;
    int t0, waited, st, bad, nrx;
    base_rx   = rx_b.size();
    base_done = done_cnt;
    base_dr   = dr_cnt;
    base_run  = runs.size();
    base_ferr = ferr;
    x = 8'h00;
    exp_q = {8'hDD, 8'h01, d, 8'(n)};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pl[8*i +: 8]);
      x = x ^ pl[8*i +: 8];
    end
    exp_q.push_back(x);

    @(negedge clk);
    dest = d; len = 8'(n); start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; dest = 8'($urandom); len = 8'($urandom);
    check({tag, " busy after start"}, busy, 1);
    check({tag, " tx start bit"}, tx, 0);

    if (restart) begin
      repeat (2 * CH + 5) @(negedge clk);
      start = 1'b1; dest = 8'h77; len = 8'h02;
      @(negedge clk);
      start = 1'b0;
    end

    for (int i = 0; i < n; i++) begin
      if (rnd_stall) st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
      else st = (i == stall_idx) ? 2000 : 0;
      if (st >= 1000) begin
        repeat (st - 1000) @(negedge clk);
        bad = 0;
        repeat (1000) begin
          @(negedge clk);
          if (tx !== 1'b1 || data_ready !== 1'b1) bad++;
        end
        check({tag, " underrun idle/ready"}, bad, 0);
      end else begin
        repeat (st) @(negedge clk);
      end
      data = pl[8*i +: 8]; data_valid = 1'b1;
      waited = 0;
      while (data_ready !== 1'b1 && waited < 4 * CH) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("%s data_ready byte%0d", tag, i), data_ready, 1);
      @(negedge clk);
      data_valid = 1'b0; data = 8'($urandom);
      check($sformatf("%s ready drop byte%0d", tag, i), data_ready, 0);
    end

    waited = 0;
    while (done !== 1'b1 && waited < 8 * CH) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy low at done"}, busy, 0);
    if (!rnd_stall && stall_idx < 0)
      check({tag, " frame duration"}, cyc - t0, (5 + n) * CH + 1);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    repeat (restart ? 6 * CH : 2 * DIV) @(negedge clk);

    nrx = rx_b.size() - base_rx;
    check({tag, " byte count"}, nrx, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nrx; i++)
      check($sformatf("%s byte%0d", tag, i), rx_b[base_rx + i], exp_q[i]);
    if (exp_crc >= 0 && nrx == exp_q.size())
      check({tag, " crc"}, rx_b[base_rx + nrx - 1], exp_crc);
    check({tag, " done pulses"}, done_cnt - base_done, 1);
    check({tag, " framing errors"}, ferr - base_ferr, 0);
    if (n == 0) check({tag, " data_ready never"}, dr_cnt - base_dr, 0);
    if (nrx >= 2) begin
      check({tag, " first start cycle"}, rx_st[base_rx], t0 + 1);
      check({tag, " char spacing"}, rx_st[base_rx + 1] - rx_st[base_rx], CH);
    end
    if (runs.size() > base_run)
      check({tag, " start bit width"}, runs[base_run], DIV);
  endtask

  typedef struct {
    logic [7:0]  dest;
    int          n;
    logic [63:0] pl;
    int          stall_idx;
    bit          restart;
    int          crc;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   t0;
    tbl[0] = '{8'h13, 1, 64'h00000000_000000AE, -1, 1'b0, 'hAE};
    tbl[1] = '{8'h13, 3, 64'h00000000_00040201, -1, 1'b0, 'h07};
    tbl[2] = '{8'h13, 0, 64'h0, -1, 1'b0, 'h00};
    tbl[3] = '{8'h42, 3, 64'h00000000_00442211, 1, 1'b0, 'h77};
    tbl[4] = '{8'h13, 2, 64'h00000000_00000FF0, -1, 1'b1, 'hFF};
    tbl[5] = '{8'hA5, 8, 64'h80402010_08040201, -1, 1'b0, 'hFF};

    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset data_ready", data_ready, 0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 6; k++)
      run_frame($sformatf("tbl%0d", k), tbl[k].dest, tbl[k].n, tbl[k].pl,
                tbl[k].stall_idx, 1'b0, tbl[k].restart, tbl[k].crc);

    for (int k = 0; k < 6; k++)
      run_frame($sformatf("rnd%0d", k), 8'($urandom), int'($urandom_range(0, 6)),
                {$urandom, $urandom}, -1, 1'b1, 1'b0, -1);

    // Reset in the middle of the second payload byte (all-zero data bits).
    @(negedge clk);
    dest = 8'h13; len = 8'd4; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; data = 8'h00; data_valid = 1'b1;
    while (cyc < t0 + 5 * CH + 35) @(negedge clk);
    check("pre-reset tx low", tx, 0);
    n_rst = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset data_ready", data_ready, 0);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("held reset tx", tx, 1);
    n_rst = 1'b1;
    repeat (2 * CH) @(negedge clk);
    check("after reset busy", busy, 0);
    run_frame("post-reset", tbl[1].dest, tbl[1].n, tbl[1].pl, -1, 1'b0, 1'b0, tbl[1].crc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
